uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
UART receive path, the counterpart of the existing transmitter, sharing its 16x oversampling baud_tick. Frame format is 8N1, LSB first, idle high: one start bit (0), 8 data bits, one stop bit (1). The block synchronises the asynchronous rx line, detects the start bit and samples each bit at mid-period. It presents each received byte with a one-cycle valid strobe, and a framing-error strobe when the stop bit is bad. It sits between the FPGA rx pin and the byte consumer (command parser / FIFO).

Parameters:
OVERSAMPLE, 16, baud_ticks per bit period; must be even and >= 4
DATA_BITS, 8, data bits per frame; data port width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
baud_tick  in  1  one-clk pulse, OVERSAMPLE pulses per bit period (16 x baud)
rx  in  1  asynchronous serial input, idle high
data  out  DATA_BITS  last received byte; held until the next frame completes
valid  out  1  one-clk pulse: data updated with a good frame
frame_err  out  1  one-clk pulse: stop bit sampled low
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: this is already decided. There is one clock, clk. Reset rst is synchronous and active-high. On reset: state=IDLE, data=0, valid=0, frame_err=0, busy=0, synchroniser flops=1, tick_cnt=0, bit_cnt=0, shift register=0. A reset mid-frame abandons the frame silently, with no strobes.
- Synchroniser: rx passes through 2 flops, both resetting to 1, to give rx_s. All decisions use rx_s only.
- tick_cnt: width clog2(OVERSAMPLE). It changes only on clocks where baud_tick=1.
- IDLE: on baud_tick with rx_s=0, go to START and set tick_cnt=0. Otherwise stay in IDLE.
- START:
  - On baud_tick with tick_cnt=OVERSAMPLE/2-1, sample rx_s (mid start bit).
  - If the sample is 0: go to DATA, set tick_cnt=0 and bit_cnt=0.
  - If the sample is 1: treat it as a glitch and return to IDLE with no strobe.
  - On any other baud_tick, increment tick_cnt.
- DATA:
  - On baud_tick with tick_cnt=OVERSAMPLE-1, sample: shreg <= {rx_s, shreg[DATA_BITS-1:1]}. Then set tick_cnt=0 and increment bit_cnt.
  - When the sample taken is bit DATA_BITS-1, go to STOP.
  - On any other baud_tick, increment tick_cnt.
- STOP: on baud_tick with tick_cnt=OVERSAMPLE-1, sample rx_s.
  - If 1: data <= shreg, valid=1 for exactly one clk, go to IDLE.
  - If 0: frame_err=1 for exactly one clk, data unchanged, go to BREAK.
- BREAK: stay until a baud_tick with rx_s=1, then go to IDLE. This prevents a held-low line from retriggering frames.
- Latency: valid/frame_err assert on the clk following the baud_tick that samples the stop bit. They are registered outputs, never both high together.
- No backpressure. A consumer must take data within one frame time; data is overwritten by the next good frame.
- Back-to-back frames: IDLE is re-entered at mid stop bit, so a start edge immediately after the stop bit is detected. No idle gap is required.
- baud_tick asserted on consecutive clks is legal; each counts as one tick.
- Sampling point tolerance: a bit-period mismatch of up to ±(OVERSAMPLE/2-1) ticks accumulated over the frame is still decoded correctly.

Test Plan:
1. Bench baud_tick every 4 clk; send 0xA5 (8N1) → data=0xA5, valid high exactly 1 clk, frame_err=0, busy low after.
2. rx low for 3 baud_ticks, then high → no valid, no frame_err, busy returns to 0, next frame 0x3C received correctly.
3. Send 0x3C with stop bit 0, then hold rx low 40 ticks → frame_err 1-clk pulse, data keeps previous value, state held in BREAK; after rx returns high, frame 0x81 gives valid with data=0x81.
4. Back-to-back 0x00, 0xFF, 0x55 with zero idle gap → three valid pulses carrying 0x00, 0xFF, 0x55 in order.
5. Assert rst during data bit 4 of 0xF0 → all outputs 0 on next clk, no strobes; subsequent 0x5A received correctly.
6. Transmit 0x96 with bit periods of 15 and of 17 ticks → data=0x96 and valid in both cases.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receive path, 16x oversampled from a shared baud_tick.
// Two-flop synchroniser, mid-bit sampling, one-clk valid / frame_err strobes.
module uart_receiver #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS);

  localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StStop  = 3'd3;
  localparam logic [2:0] StBreak = 3'd4;

  logic                 rx_meta_q, rx_s_q;
  logic [2:0]           state_q, state_d;
  logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    if (baud_tick) begin
      case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            state_d    = StStart;
            tick_cnt_d = '0;
          end
        end
        StStart: begin
          if (tick_cnt_q == TickHalf) begin
            // A start bit that is high again at mid-period was only a glitch.
            if (!rx_s_q) begin
              state_d    = StData;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        StData: begin
          if (tick_cnt_q == TickLast) begin
            shreg_d    = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BitLast) begin
              state_d = StStop;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (tick_cnt_q == TickLast) begin
            if (rx_s_q) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
              state_d = StIdle;
            end else begin
              frame_err_d = 1'b1;
              state_d     = StBreak;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        StBreak: begin
          // Hold here while the line is low so a break cannot retrigger frames.
          if (rx_s_q) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= StIdle;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames are driven bit by bit on baud_tick,
// expected strobes are queued at send time and matched when the DUT strobes.
module tb_uart_receiver;

  typedef struct packed {
    logic       err;
    logic [7:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int         checks = 0;
  int         failures = 0;
  int         div = 0;
  exp_t       sb[$];
  logic [7:0] last_good = 8'h00;

  uart_receiver #(
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .baud_tick(baud_tick),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // baud_tick every 4 clk, changed on the falling edge so it is stable at posedge.
  always @(negedge clk) begin
    div = (div + 1) % 4;
    baud_tick = (div == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) @(posedge clk iff baud_tick);
    #1;
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    wait_ticks(n);
  endtask

  // The first nskew bit periods last 'period' ticks, the rest 16.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int nskew,
                            input int period);
    exp_t e;
    logic v;
    e.err = ~stop;
    e.d   = stop ? b : last_good;
    sb.push_back(e);
    if (stop) last_good = b;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) v = 1'b0;
      else if (i == 9) v = stop;
      else v = b[i-1];
      drive_bit(v, (i < nskew) ? period : 16);
    end
  endtask

  initial begin
    exp_t e;

    fork
      forever begin
        @(negedge clk);
        if (valid === 1'b1 || frame_err === 1'b1) begin
          if (sb.size() == 0) begin
            check("unexpected_strobe", 32'({valid, frame_err}), 32'd0);
          end else begin
            e = sb.pop_front();
            check("strobe_kind", 32'({valid, frame_err}), e.err ? 32'd1 : 32'd2);
            check("strobe_data", 32'(data), 32'(e.d));
          end
        end
      end
    join_none

    repeat (4) @(negedge clk);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk iff baud_tick);
    #1;
    drive_bit(1'b1, 8);

    // Plain frame
    send_frame(8'hA5, 1'b1, 0, 16);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_data", 32'(data), 32'hA5);
    check("t1_valid_low", 32'(valid), 32'd0);

    // Start-bit glitch, then a real frame
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 20);
    check("t2_glitch_busy", 32'(busy), 32'd0);
    send_frame(8'h3C, 1'b1, 0, 16);

    // Bad stop bit followed by a long break
    send_frame(8'h3C, 1'b0, 0, 16);
    drive_bit(1'b0, 40);
    check("t3_break_busy", 32'(busy), 32'd1);
    drive_bit(1'b1, 16);
    check("t3_idle_busy", 32'(busy), 32'd0);
    check("t3_data_held", 32'(data), 32'h3C);
    send_frame(8'h81, 1'b1, 0, 16);

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1, 0, 16);
    send_frame(8'hFF, 1'b1, 0, 16);
    send_frame(8'h55, 1'b1, 0, 16);
    check("t4_data_last", 32'(data), 32'h55);

    // Reset in the middle of data bit 4 of 0xF0
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 16);
    drive_bit(1'b1, 8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_data", 32'(data), 32'h00);
    check("t5_rst_valid", 32'(valid), 32'd0);
    check("t5_rst_frame_err", 32'(frame_err), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    last_good = 8'h00;
    @(posedge clk iff baud_tick);
    #1;
    drive_bit(1'b1, 20);
    send_frame(8'h5A, 1'b1, 0, 16);
    check("t5_data", 32'(data), 32'h5A);

    // Bit-period skew: five periods of 15 / 17 ticks keeps drift within +-7 ticks
    drive_bit(1'b1, 16);
    send_frame(8'h96, 1'b1, 5, 15);
    check("t6_short_data", 32'(data), 32'h96);
    drive_bit(1'b1, 16);
    send_frame(8'h96, 1'b1, 5, 17);
    check("t6_long_data", 32'(data), 32'h96);

    drive_bit(1'b1, 16);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
